// File: rtl/jogo_genius_param_if.sv
// rtl/jogo_genius_param_if.sv - player-side signal bundle of the memory game
interface jogo_genius_param_if #(
    parameter int N_BOTOES = 4
);
    logic                iniciar;
    logic                modo;
    logic [N_BOTOES-1:0] chaves;
    logic                pronto;
    logic                acertou;
    logic                errou;
    logic                timeout;
    logic [N_BOTOES-1:0] leds;

    modport master (
        output iniciar, modo, chaves,
        input  pronto, acertou, errou, timeout, leds
    );

    modport slave (
        input  iniciar, modo, chaves,
        output pronto, acertou, errou, timeout, leds
    );
endinterface

// File: rtl/jogo_genius_param.sv
// rtl/jogo_genius_param.sv - parameterised Genius/Simon sequence game with optional play timeout
module jogo_genius_param #(
    parameter int N_BOTOES     = 4,
    parameter int PROFUNDIDADE = 16,
    parameter logic [PROFUNDIDADE*N_BOTOES-1:0] SEQUENCIA = 64'h4188_4422_1124_8421,
    parameter int TIMEOUT      = 0,
    localparam int ADDR_W      = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1
) (
    input  logic              clock,
    input  logic              reset,
    jogo_genius_param_if.slave bus,
    output logic [3:0]        db_estado,
    output logic [ADDR_W-1:0] db_endereco,
    output logic [ADDR_W-1:0] db_rodada,
    output logic              db_igual,
    output logic              db_tem_jogada
);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [ADDR_W-1:0] ULTIMO       = ADDR_W'(PROFUNDIDADE - 1);
    localparam logic [TW-1:0]     TIMER_LIMITE = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h2,
        COMPARA     = 4'h3,
        PROXIMA     = 4'h4,
        PROX_RODADA = 4'h5,
        FIM_ACERTO  = 4'hA,
        FIM_ERRO    = 4'hE,
        FIM_TIMEOUT = 4'hF
    } estado_t;

    estado_t             estado;
    estado_t             proximo;
    logic [N_BOTOES-1:0] chaves_r;
    logic [N_BOTOES-1:0] jogada;
    logic [N_BOTOES-1:0] esperado;
    logic [ADDR_W-1:0]   endereco;
    logic [ADDR_W-1:0]   rodada;
    logic [TW-1:0]       timer;
    logic                tem_jogada;
    logic                igual;
    logic                estourou;

    assign tem_jogada = (bus.chaves != '0) && (chaves_r == '0);
    assign esperado   = SEQUENCIA[endereco*N_BOTOES +: N_BOTOES];
    // A multi-hot play must lose even if the stored element were multi-hot.
    assign igual      = (jogada == esperado) && (jogada != '0)
                        && ((jogada & (jogada - N_BOTOES'(1))) == '0);
    assign estourou   = (TIMEOUT > 0) && (timer == TIMER_LIMITE);

    always_comb begin
        proximo = estado;
        case (estado)
            INICIAL:     if (bus.iniciar) proximo = PREPARA;
            PREPARA:     proximo = ESPERA;
            ESPERA: begin
                if (tem_jogada)    proximo = COMPARA;
                else if (estourou) proximo = FIM_TIMEOUT;
            end
            COMPARA: begin
                if (!igual)                 proximo = FIM_ERRO;
                else if (endereco < rodada) proximo = PROXIMA;
                else if (rodada == ULTIMO)  proximo = FIM_ACERTO;
                else                        proximo = PROX_RODADA;
            end
            PROXIMA, PROX_RODADA: proximo = ESPERA;
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (bus.iniciar) proximo = PREPARA;
            default:     proximo = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) estado <= INICIAL;
        else       estado <= proximo;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            chaves_r <= '0;
            jogada   <= '0;
            endereco <= '0;
            rodada   <= '0;
            timer    <= '0;
        end else begin
            chaves_r <= bus.chaves;
            case (estado)
                PREPARA: begin
                    endereco <= '0;
                    jogada   <= '0;
                    timer    <= '0;
                    rodada   <= bus.modo ? '0 : ULTIMO;
                end
                ESPERA: begin
                    if (tem_jogada)      jogada <= bus.chaves;
                    else if (timer != '1) timer <= timer + TW'(1);
                end
                PROXIMA: begin
                    endereco <= endereco + ADDR_W'(1);
                    timer    <= '0;
                end
                PROX_RODADA: begin
                    rodada   <= rodada + ADDR_W'(1);
                    endereco <= '0;
                    timer    <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.pronto   = (estado == FIM_ACERTO) || (estado == FIM_ERRO) || (estado == FIM_TIMEOUT);
    assign bus.acertou  = (estado == FIM_ACERTO);
    assign bus.errou    = (estado == FIM_ERRO) || (estado == FIM_TIMEOUT);
    assign bus.timeout  = (estado == FIM_TIMEOUT);
    assign bus.leds     = jogada;
    assign db_estado     = estado;
    assign db_endereco   = endereco;
    assign db_rodada     = rodada;
    assign db_igual      = igual;
    assign db_tem_jogada = tem_jogada;
endmodule

// File: tb/tb_jogo_genius_param.sv
// tb/tb_jogo_genius_param.sv - self-checking bench for jogo_genius_param
module tb_jogo_genius_param;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic sel   = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] leds;
        logic [3:0] endr;
        logic [3:0] rod;
    } exp_t;
    exp_t sb[$];

    logic [3:0] seq4 [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                              4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};
    logic [7:0] seq8 [4]  = '{8'h80, 8'h01, 8'h10, 8'h02};

    jogo_genius_param_if #(.N_BOTOES(4)) g_if ();
    jogo_genius_param_if #(.N_BOTOES(4)) t_if ();
    jogo_genius_param_if #(.N_BOTOES(8)) w_if ();

    logic [3:0] g_est, g_end, g_rod, t_est, t_end, t_rod, w_est;
    logic [1:0] w_end, w_rod;
    logic       g_ig, g_tj, t_ig, t_tj, w_ig, w_tj;

    jogo_genius_param dut (
        .clock(clock), .reset(reset), .bus(g_if.slave), .db_estado(g_est),
        .db_endereco(g_end), .db_rodada(g_rod), .db_igual(g_ig), .db_tem_jogada(g_tj)
    );
    jogo_genius_param #(.TIMEOUT(20)) dut_t (
        .clock(clock), .reset(reset), .bus(t_if.slave), .db_estado(t_est),
        .db_endereco(t_end), .db_rodada(t_rod), .db_igual(t_ig), .db_tem_jogada(t_tj)
    );
    jogo_genius_param #(.N_BOTOES(8), .PROFUNDIDADE(4), .SEQUENCIA(32'h0210_0180)) dut_w (
        .clock(clock), .reset(reset), .bus(w_if.slave), .db_estado(w_est),
        .db_endereco(w_end), .db_rodada(w_rod), .db_igual(w_ig), .db_tem_jogada(w_tj)
    );

    assign t_if.iniciar = g_if.iniciar;
    assign t_if.modo    = g_if.modo;
    assign t_if.chaves  = g_if.chaves;

    wire [3:0] o_est     = sel ? w_est : g_est;
    wire [7:0] o_leds    = sel ? w_if.leds : {4'h0, g_if.leds};
    wire [3:0] o_end     = sel ? {2'b00, w_end} : g_end;
    wire [3:0] o_rod     = sel ? {2'b00, w_rod} : g_rod;
    wire       o_pronto  = sel ? w_if.pronto : g_if.pronto;
    wire       o_acertou = sel ? w_if.acertou : g_if.acertou;
    wire       o_errou   = sel ? w_if.errou : g_if.errou;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [7:0] v);
        if (sel) w_if.chaves = v;
        else     g_if.chaves = v[3:0];
    endtask

    task automatic start(input logic m);
        reset = 1'b1;
        drive(8'h00);
        tick();
        reset = 1'b0;
        if (sel) begin w_if.modo = m; w_if.iniciar = 1'b1; end
        else     begin g_if.modo = m; g_if.iniciar = 1'b1; end
        tick();
        w_if.iniciar = 1'b0;
        g_if.iniciar = 1'b0;
        tick();
    endtask

    task automatic play(input logic [7:0] v, input logic [3:0] e, input logic [3:0] r,
                        input int hold, input int idle);
        exp_t x;
        bit   seen = 1'b0;
        x.leds = v; x.endr = e; x.rod = r;
        sb.push_back(x);
        drive(v);
        for (int i = 0; i < hold + idle; i++) begin
            if (i == hold) drive(8'h00);
            tick();
            if (o_est == 4'h3 && !seen) begin
                seen = 1'b1;
                x = sb.pop_front();
                checks++;
                if ({o_leds, o_end, o_rod} !== {x.leds, x.endr, x.rod}) begin
                    errors++;
                    $display("FAIL play_capture: leds/end/rod got %h/%h/%h expected %h/%h/%h",
                             o_leds, o_end, o_rod, x.leds, x.endr, x.rod);
                end
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL play_accept: play %h never reached COMPARA, state %h", v, o_est);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    task automatic test_reset();
        g_if.iniciar = 1'b1; g_if.modo = 1'b0; g_if.chaves = '0;
        w_if.iniciar = 1'b1; w_if.modo = 1'b0; w_if.chaves = '0;
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({g_if.pronto, g_if.acertou, g_if.errou, g_if.timeout, g_if.leds, g_est, g_end, g_rod, g_ig, g_tj} !== '0) begin
            errors++; $display("FAIL reset_outputs_main: state %h leds %h pronto %b", g_est, g_if.leds, g_if.pronto);
        end
        checks++;
        if ({w_if.pronto, w_if.errou, w_if.leds, w_est, w_end, w_rod, w_ig, w_tj} !== '0) begin
            errors++; $display("FAIL reset_outputs_wide: state %h leds %h", w_est, w_if.leds);
        end
        g_if.iniciar = 1'b0; w_if.iniciar = 1'b0; reset = 1'b0;
        tick();
        checks++;
        if (g_est !== 4'h0) begin errors++; $display("FAIL reset_idle: state %h expected 0", g_est); end
    endtask

    task automatic test_erro_modo0();
        sel = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        g_if.modo = 1'b0; g_if.iniciar = 1'b1;
        repeat (5) tick();
        g_if.iniciar = 1'b0;
        checks++;
        if (o_est !== 4'h2) begin errors++; $display("FAIL erro_espera: state %h expected 2", o_est); end
        for (int i = 0; i < 4; i++) play({4'h0, seq4[i]}, 4'(i), 4'hF, 2, 2);
        play(8'h01, 4'h4, 4'hF, 2, 2);
        checks++;
        if ({o_pronto, o_acertou, o_errou, o_est, o_end} !== {3'b101, 4'hE, 4'h4}) begin
            errors++; $display("FAIL erro_end: p/a/e %b%b%b state %h end %h expected 101 E 4",
                               o_pronto, o_acertou, o_errou, o_est, o_end);
        end
    endtask

    task automatic test_acerto_modo0();
        sel = 1'b0;
        start(1'b0);
        for (int i = 0; i < 16; i++) play({4'h0, seq4[i]}, 4'(i), 4'hF, 10, 10);
        checks++;
        if ({o_pronto, o_acertou, o_errou, o_est, o_leds} !== {3'b110, 4'hA, 8'h04}) begin
            errors++; $display("FAIL acerto_end: p/a/e %b%b%b state %h leds %h expected 110 A 04",
                               o_pronto, o_acertou, o_errou, o_est, o_leds);
        end
    endtask

    task automatic test_latency();
        logic [3:0] trace [3];
        sel = 1'b0;
        start(1'b0);
        drive(8'h01);
        tick(); trace[0] = o_est;
        drive(8'h00);
        tick(); trace[1] = o_est;
        tick(); trace[2] = o_est;
        checks++;
        if ({trace[0], trace[1], trace[2]} !== 12'h342) begin
            errors++; $display("FAIL latency_states: got %h%h%h expected 342", trace[0], trace[1], trace[2]);
        end
        play(8'h02, 4'h1, 4'hF, 2, 2);
    endtask

    task automatic test_progressivo();
        sel = 1'b0;
        start(1'b1);
        for (int r = 0; r < 16; r++) begin
            for (int e = 0; e <= r; e++) play({4'h0, seq4[e]}, 4'(e), 4'(r), 2, 2);
            if (r == 14) begin
                checks++;
                if ({o_pronto, o_acertou, o_est, o_rod} !== {2'b00, 4'h2, 4'hF}) begin
                    errors++; $display("FAIL prog_before_last: pronto %b acertou %b state %h rod %h expected 0 0 2 F",
                                       o_pronto, o_acertou, o_est, o_rod);
                end
            end
        end
        checks++;
        if ({o_pronto, o_acertou, o_errou, o_est, o_rod} !== {3'b110, 4'hA, 4'hF}) begin
            errors++; $display("FAIL prog_won: p/a/e %b%b%b state %h rod %h expected 110 A F",
                               o_pronto, o_acertou, o_errou, o_est, o_rod);
        end
        start(1'b1);
        for (int r = 0; r < 2; r++)
            for (int e = 0; e <= r; e++) play({4'h0, seq4[e]}, 4'(e), 4'(r), 2, 2);
        play({4'h0, seq4[0]}, 4'h0, 4'h2, 2, 2);
        play(8'h08, 4'h1, 4'h2, 2, 2);
        checks++;
        if ({o_errou, o_acertou, o_est, o_rod} !== {2'b10, 4'hE, 4'h2}) begin
            errors++; $display("FAIL prog_wrong: errou %b acertou %b state %h rod %h expected 1 0 E 2",
                               o_errou, o_acertou, o_est, o_rod);
        end
    endtask

    task automatic test_timeout();
        sel = 1'b0;
        start(1'b0);
        repeat (19) tick();
        checks++;
        if (t_est !== 4'h2) begin errors++; $display("FAIL timeout_early: state %h expected 2", t_est); end
        tick();
        checks++;
        if ({t_est, t_if.pronto, t_if.errou, t_if.timeout, t_if.acertou} !== {4'hF, 4'b1110}) begin
            errors++; $display("FAIL timeout_fire: state %h p/e/t/a %b%b%b%b expected F 1110",
                               t_est, t_if.pronto, t_if.errou, t_if.timeout, t_if.acertou);
        end
        checks++;
        if (g_est !== 4'h2) begin errors++; $display("FAIL timeout_disabled: state %h expected 2", g_est); end
        start(1'b0);
        repeat (19) tick();
        g_if.chaves = 4'h1;
        tick();
        g_if.chaves = 4'h0;
        checks++;
        if ({t_est, t_if.timeout, t_if.leds} !== {4'h3, 1'b0, 4'h1}) begin
            errors++; $display("FAIL timeout_last_cycle_play: state %h timeout %b leds %h expected 3 0 1",
                               t_est, t_if.timeout, t_if.leds);
        end
    endtask

    task automatic test_held_multi_reset();
        sel = 1'b0;
        start(1'b0);
        play(8'h01, 4'h0, 4'hF, 30, 2);
        checks++;
        if ({o_est, o_end} !== {4'h2, 4'h1}) begin
            errors++; $display("FAIL held_single: state %h end %h expected 2 1", o_est, o_end);
        end
        play(8'h03, 4'h1, 4'hF, 2, 2);
        checks++;
        if ({o_errou, o_est} !== {1'b1, 4'hE}) begin
            errors++; $display("FAIL multi_hot: errou %b state %h expected 1 E", o_errou, o_est);
        end
        start(1'b0);
        play(8'h01, 4'h0, 4'hF, 2, 2);
        play(8'h02, 4'h1, 4'hF, 2, 2);
        drive(8'h04);
        reset = 1'b1;
        tick();
        checks++;
        if ({g_est, g_if.leds} !== 8'h00) begin
            errors++; $display("FAIL reset_mid_play: state %h leds %h expected 0 0", g_est, g_if.leds);
        end
        drive(8'h00);
        reset = 1'b0;
        tick();
        checks++;
        if ({g_if.pronto, g_if.acertou, g_if.errou, g_if.timeout, g_if.leds, g_est, g_end, g_rod, g_ig, g_tj} !== '0) begin
            errors++; $display("FAIL reset_mid_outputs: state %h end %h rod %h", g_est, g_end, g_rod);
        end
        g_if.iniciar = 1'b1; tick();
        g_if.iniciar = 1'b0; tick();
        checks++;
        if ({g_est, g_end} !== {4'h2, 4'h0}) begin
            errors++; $display("FAIL restart_after_reset: state %h end %h expected 2 0", g_est, g_end);
        end
        play(8'h01, 4'h0, 4'hF, 2, 2);
    endtask

    task automatic test_botoes8();
        sel = 1'b1;
        start(1'b0);
        for (int i = 0; i < 4; i++) play(seq8[i], 4'(i), 4'h3, 2, 2);
        checks++;
        if ({o_pronto, o_acertou, o_errou, o_est, o_leds} !== {3'b110, 4'hA, 8'h02}) begin
            errors++; $display("FAIL wide_won: p/a/e %b%b%b state %h leds %h expected 110 A 02",
                               o_pronto, o_acertou, o_errou, o_est, o_leds);
        end
        w_if.iniciar = 1'b1; tick();
        w_if.iniciar = 1'b0;
        checks++;
        if ({o_pronto, o_est} !== {1'b0, 4'h1}) begin
            errors++; $display("FAIL wide_restart: pronto %b state %h expected 0 1", o_pronto, o_est);
        end
        tick();
        checks++;
        if ({o_est, o_end, o_leds} !== {4'h2, 4'h0, 8'h00}) begin
            errors++; $display("FAIL wide_new_game: state %h end %h leds %h expected 2 0 00", o_est, o_end, o_leds);
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_erro_modo0();
        test_acerto_modo0();
        test_latency();
        test_progressivo();
        test_timeout();
        test_held_multi_reset();
        test_botoes8();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jogo_genius_param.md
JOGO_GENIUS_PARAM -- requirements
Module: jogo_genius_param

Interface
REQ-001 SHALL have parameter N_BOTOES, default 4: number of buttons, one-hot play width (2..8).
REQ-002 SHALL have parameter PROFUNDIDADE, default 16: sequence length (2..64); ADDR_W = clog2(PROFUNDIDADE).
REQ-003 SHALL have parameter SEQUENCIA, default element-hex 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4: packed PROFUNDIDADE*N_BOTOES bits; element i at bits [i*N_BOTOES +: N_BOTOES].
REQ-004 SHALL have parameter TIMEOUT, default 0: cycles allowed per play; 0 disables timeout.
REQ-005 SHALL have ports: clock  in  1  sole clock, rising edge; reset  in  1  synchronous, active-high.
REQ-006 SHALL have ports: iniciar  in  1  start game; modo  in  1  0 = single pass of all plays, 1 = progressive rounds; chaves  in  N_BOTOES  player buttons.
REQ-007 SHALL have ports: pronto  out  1  game ended; acertou  out  1  won; errou  out  1  lost; timeout  out  1  lost by timeout; leds  out  N_BOTOES  last captured play.
REQ-008 SHALL have debug ports: db_estado  out  4  state code; db_endereco  out  ADDR_W  play index; db_rodada  out  ADDR_W  current round limit; db_igual  out  1  compare result; db_tem_jogada  out  1  edge detect.

Function
REQ-009 SHALL register chaves every cycle; tem_jogada = (chaves != 0) AND (registered chaves == 0).
REQ-010 SHALL implement states/codes: INICIAL 0, PREPARA 1, ESPERA 2, COMPARA 3, PROXIMA 4, PROX_RODADA 5, FIM_ACERTO A, FIM_ERRO E, FIM_TIMEOUT F; db_estado = code.
REQ-011 INICIAL: iniciar=1 -> PREPARA; else stay.
REQ-012 PREPARA (1 cycle): endereco=0, jogada register=0, timer=0; rodada=0 if modo=1 else PROFUNDIDADE-1; modo latched here -> ESPERA.
REQ-013 ESPERA: tem_jogada=1 -> jogada register loads chaves, -> COMPARA; timer increments each cycle otherwise.
REQ-014 ESPERA with TIMEOUT>0 and timer == TIMEOUT-1 and no tem_jogada -> FIM_TIMEOUT; simultaneous tem_jogada wins (goes to COMPARA).
REQ-015 COMPARA: db_igual = (jogada == SEQUENCIA[endereco]); multi-hot play never equal.
REQ-016 COMPARA: not igual -> FIM_ERRO; igual and endereco<rodada -> PROXIMA; igual and endereco==rodada and rodada==PROFUNDIDADE-1 -> FIM_ACERTO; igual and endereco==rodada otherwise -> PROX_RODADA.
REQ-017 PROXIMA: endereco+1, timer=0 -> ESPERA.
REQ-018 PROX_RODADA: rodada+1, endereco=0, timer=0 -> ESPERA.
REQ-019 FIM_* states: hold outputs; iniciar=1 -> PREPARA (restart); else stay.
REQ-020 iniciar SHALL be ignored in PREPARA, ESPERA, COMPARA, PROXIMA, PROX_RODADA.
REQ-021 pronto=1 in any FIM_*; acertou=1 only in FIM_ACERTO; errou=1 in FIM_ERRO and FIM_TIMEOUT; timeout=1 only in FIM_TIMEOUT; all Moore, registered-state decoded.
REQ-022 leds SHALL equal jogada register; db_endereco/db_rodada SHALL equal internal counters.
REQ-023 Counters SHALL never exceed PROFUNDIDADE-1; timer width clog2(TIMEOUT+1), saturating not wrapping.
REQ-024 Latency: correct play edge in ESPERA -> next play accepted in ESPERA 3 cycles later (ESPERA, COMPARA, PROXIMA).

Reset
REQ-025 reset=1 at rising edge SHALL force INICIAL, counters=0, jogada=0, chaves register=0 from any state, including mid-game; all outputs 0 the following cycle.
REQ-026 reset SHALL dominate iniciar and tem_jogada in the same cycle.

Verification
REQ-027 modo=0, defaults: reset, iniciar 5 cycles, plays 1,2,4,8 then 1 -> errou=1, pronto=1, acertou=0, db_estado=E, db_endereco=4.
REQ-028 modo=0: all 16 correct plays, each held 10 cycles with 10 idle -> acertou=1, pronto=1, leds=4'b0100, db_estado=A.
REQ-029 modo=1: rounds 0..15 each replayed from index 0 (136 plays total) -> acertou=1 only after round 15; db_rodada steps 0..15; wrong play in round 2 index 1 -> errou=1, db_rodada=2.
REQ-030 TIMEOUT=20, modo=0: iniciar, no plays -> FIM_TIMEOUT exactly 20 cycles after entering ESPERA, errou=1, timeout=1; play on cycle 19 -> accepted, no timeout.
REQ-031 Held button 30 cycles -> single play counted; two buttons (4'b0011) -> errou=1; reset asserted during play 3 -> INICIAL, all outputs 0, iniciar restarts at endereco 0.
REQ-032 N_BOTOES=8, PROFUNDIDADE=4, SEQUENCIA=80,01,10,02: correct plays -> acertou=1; iniciar from FIM_ACERTO -> new game, pronto=0.
